bin2bcd_disp: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 17 +
 rtl/bin2bcd_if.sv | 21 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_disp.sv | 94 +++++++++
 tb/tb_bin2bcd_disp.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD display converter.
// Included by the interface, the digit adjuster and the converter top.
package bin2bcd_pkg;

  localparam int          BIN_W       = 27;
  localparam int          N_DIGITS    = 8;
  localparam int          DIGIT_W     = 4;
  localparam int unsigned BCD_MAX_VAL = 99_999_999;
  localparam logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_if.sv
// Load/result bundle between a requester and bin2bcd_disp.
// Requester drives ld/bin/dpi; converter returns busy/done/ovf/val/dp.
interface bin2bcd_if #(
  parameter int pBinWidth = bin2bcd_pkg::BIN_W,
  parameter int pDigits   = bin2bcd_pkg::N_DIGITS
);
  import bin2bcd_pkg::*;

  logic                         ld;
  logic [pBinWidth-1:0]         bin;
  logic [pDigits-1:0]           dpi;
  logic                         busy;
  logic                         done;
  logic                         ovf;
  logic [DIGIT_W*pDigits-1:0]   val;
  logic [pDigits-1:0]           dp;

  modport master (output ld, bin, dpi, input busy, done, ovf, val, dp);
  modport slave  (input ld, bin, dpi, output busy, done, ovf, val, dp);

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more, no carry out.
// Purely combinational; one instance per output digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd_disp.sv
// Serial double-dabble binary-to-BCD converter; result/done 28 cycles after an accepted ld.
// Backpressure: ld is dropped (not queued) while busy; outputs hold the last result.
module bin2bcd_disp
  import bin2bcd_pkg::*;
#(
  parameter int          pBinWidth = BIN_W,
  parameter int          pDigits   = N_DIGITS,
  parameter int unsigned pMaxVal   = BCD_MAX_VAL
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);

  localparam int VAL_W = DIGIT_W * pDigits;

  state_t               state;
  state_t               state_nxt;
  logic [pBinWidth-1:0] shift_reg;
  logic [VAL_W-1:0]     scratch;
  logic [VAL_W-1:0]     scratch_adj;
  logic [4:0]           cnt;
  logic [pDigits-1:0]   dp_hold;
  logic                 ovf_hold;

  for (genvar i = 0; i < pDigits; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[DIGIT_W*i +: DIGIT_W]),
      .dout (scratch_adj[DIGIT_W*i +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ld) state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DONE still counts as busy so a load there cannot clobber the holding regs.
  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      dp_hold   <= '0;
      ovf_hold  <= 1'b0;
      bus.val   <= '0;
      bus.dp    <= '0;
      bus.ovf   <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld) begin
            shift_reg <= bus.bin;
            dp_hold   <= bus.dpi;
            ovf_hold  <= 32'(bus.bin) > pMaxVal;
            scratch   <= '0;
            cnt       <= 5'(pBinWidth);
          end
        end
        SHIFT: begin
          {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
          cnt                  <= cnt - 5'd1;
        end
        DONE: begin
          bus.val  <= ovf_hold ? {pDigits{OVF_PATTERN[3:0]}} : scratch;
          bus.dp   <= dp_hold;
          bus.ovf  <= ovf_hold;
          bus.done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Self-checking bench for bin2bcd_disp against a decimal reference model.
module tb_bin2bcd_disp;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bin2bcd_if bus ();

  bin2bcd_disp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: peel digits with /10 and %10, or all 'E' past the limit.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    if (v > 32'd99_999_999) return 32'hEEEE_EEEE;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge of cycle 0 after the ld edge.
  task automatic start_conv(input logic [26:0] b, input logic [7:0] d);
    bus.ld  = 1'b1;
    bus.bin = b;
    bus.dpi = d;
    @(posedge clk);
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_bad, output bit val_chg);
    logic [31:0] v0;
    v0       = bus.val;
    lat      = 0;
    busy_bad = 0;
    val_chg  = 1'b0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.val !== v0) val_chg = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    bus.ld  = 1'b0;
    bus.bin = '0;
    bus.dpi = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.val !== 32'h0) begin errors++; $display("FAIL reset_val: got %h want %h", bus.val, 32'h0); end
    checks++; if (bus.dp !== 8'h0) begin errors++; $display("FAIL reset_dp: got %h want %h", bus.dp, 8'h0); end
    checks++; if ({bus.busy, bus.done, bus.ovf} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/ovf=%b want 000", {bus.busy, bus.done, bus.ovf});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got busy/done=%b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_zero;
    int lat, bb; bit vc;
    start_conv(27'd0, 8'h00);
    wait_done(lat, bb, vc);
    checks++; if (lat != 28) begin errors++; $display("FAIL zero_latency: got %0d want 28", lat); end
    checks++; if (bb != 0) begin errors++; $display("FAIL zero_busy: got %0d low cycles want 0", bb); end
    checks++; if (bus.val !== 32'h0 || bus.ovf !== 1'b0) begin
      errors++; $display("FAIL zero_val: got %h ovf %b want 00000000 ovf 0", bus.val, bus.ovf);
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_cycle_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_digits;
    int lat, bb; bit vc;
    start_conv(27'd12_345_678, 8'h04);
    wait_done(lat, bb, vc);
    checks++; if (vc) begin errors++; $display("FAIL digits_stable: got change want none"); end
    checks++; if (bus.val !== 32'h1234_5678) begin errors++; $display("FAIL digits_val: got %h want 12345678", bus.val); end
    checks++; if (bus.dp !== 8'h04 || bus.ovf !== 1'b0) begin
      errors++; $display("FAIL digits_dp_ovf: got dp %h ovf %b want 04 0", bus.dp, bus.ovf);
    end
    repeat (10) @(negedge clk);
    checks++; if (bus.val !== 32'h1234_5678 || bus.dp !== 8'h04) begin
      errors++; $display("FAIL digits_hold: got %h/%h want 12345678/04", bus.val, bus.dp);
    end
  endtask

  task automatic test_max_ovf;
    int lat, bb; bit vc;
    start_conv(27'd99_999_999, 8'h80);
    wait_done(lat, bb, vc);
    checks++; if (bus.val !== 32'h9999_9999 || bus.ovf !== 1'b0) begin
      errors++; $display("FAIL max_val: got %h ovf %b want 99999999 ovf 0", bus.val, bus.ovf);
    end
    start_conv(27'd100_000_000, 8'h11);
    wait_done(lat, bb, vc);
    checks++; if (lat != 28) begin errors++; $display("FAIL ovf_latency: got %0d want 28", lat); end
    checks++; if (bus.val !== 32'hEEEE_EEEE || bus.ovf !== 1'b1 || bus.dp !== 8'h11) begin
      errors++; $display("FAIL ovf_val: got %h ovf %b dp %h want EEEEEEEE 1 11", bus.val, bus.ovf, bus.dp);
    end
  endtask

  task automatic test_ignore_ld;
    int c, lat, bb; bit vc;
    start_conv(27'd255, 8'h00);
    c = 0;
    while (bus.done !== 1'b1 && c < 60) begin
      bus.ld  = (c == 5 || c == 27);
      bus.bin = 27'd7;
      @(negedge clk);
      c++;
    end
    bus.ld = 1'b0;
    checks++; if (c != 28) begin errors++; $display("FAIL ignore_latency: got %0d want 28", c); end
    checks++; if (bus.val !== 32'h0000_0255) begin errors++; $display("FAIL ignore_val: got %h want 00000255", bus.val); end
    start_conv(27'd7, 8'hA5);
    wait_done(lat, bb, vc);
    checks++; if (lat != 28 || bus.val !== 32'h0000_0007 || bus.dp !== 8'hA5) begin
      errors++; $display("FAIL done_cycle_ld: got lat %0d val %h dp %h want 28 00000007 a5", lat, bus.val, bus.dp);
    end
  endtask

  task automatic test_mid_reset;
    int lat, bb, seen; bit vc;
    start_conv(27'd4_096, 8'h3C);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.val !== 32'h0 || bus.dp !== 8'h0) begin
      errors++; $display("FAIL async_reset_val: got %h/%h want 00000000/00", bus.val, bus.dp);
    end
    checks++; if ({bus.busy, bus.done, bus.ovf} !== 3'b000) begin
      errors++; $display("FAIL async_reset_flags: got %b want 000", {bus.busy, bus.done, bus.ovf});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++; if (seen != 0 || bus.val !== 32'h0) begin
      errors++; $display("FAIL discard_inflight: got %0d done pulses val %h want 0 00000000", seen, bus.val);
    end
    start_conv(27'd42, 8'h01);
    wait_done(lat, bb, vc);
    checks++; if (lat != 28 || bus.val !== 32'h0000_0042) begin
      errors++; $display("FAIL post_reset_conv: got lat %0d val %h want 28 00000042", lat, bus.val);
    end
  endtask

  task automatic test_random;
    int lat, bb; bit vc;
    logic [26:0] b;
    logic [7:0]  d;
    for (int n = 0; n < 1500; n++) begin
      b = 27'($urandom);
      d = 8'($urandom);
      if (n % 5 == 0) b = 27'(99_999_999 - 3 + $urandom_range(0, 6));
      start_conv(b, d);
      wait_done(lat, bb, vc);
      checks++;
      if (lat != 28 || bb != 0 || bus.val !== ref_bcd(32'(b)) || bus.dp !== d ||
          bus.ovf !== (32'(b) > 32'd99_999_999)) begin
        errors++;
        $display("FAIL random bin=%0d: got lat %0d val %h dp %h ovf %b want 28 %h %h %b",
                 b, lat, bus.val, bus.dp, bus.ovf, ref_bcd(32'(b)), d, 32'(b) > 32'd99_999_999);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_digits();
    test_max_ovf();
    test_ignore_ld();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
